// File: rtl/temporal_pkg.sv
// Types shared by the temporal encoder and the downstream temporal decoder.
package temporal_pkg;

    // Gamma-cycle sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SETUP = 2'd1,
        RUN   = 2'd2
    } enc_state_t;

endpackage

// File: rtl/temporal_encoder_pulse_gen.sv
// Per-channel spike generator: latches one channel's value on load and raises
// a registered spike while the gamma counter sits inside [v, v+PW-1].
module pulse_gen
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic             aclk,
    input  logic             grst,
    input  logic             load,
    input  logic [VAL_W-1:0] value,
    input  logic             nospike,
    input  logic [VAL_W-1:0] gcnt,
    input  logic             run,
    output logic             spike
);

    // One extra bit keeps v+PW-1 from wrapping; the pulse is truncated for
    // free because gcnt never exceeds G-1.
    localparam logic [VAL_W:0] PW_M1 = (VAL_W+1)'(PULSE_WIDTH - 1);

    logic [VAL_W-1:0] value_q;
    logic             nospike_q;
    logic [VAL_W:0]   win_lo;
    logic [VAL_W:0]   win_hi;
    logic [VAL_W:0]   t_ext;
    logic             hit;

    assign win_lo = {1'b0, value_q};
    assign win_hi = win_lo + PW_M1;
    assign t_ext  = {1'b0, gcnt};
    assign hit    = run && !nospike_q && (t_ext >= win_lo) && (t_ext <= win_hi);

    // Latch the channel value on accept; gcnt/run arrive as next-cycle values
    // so the spike register lines up with the counter.
    always_ff @(posedge aclk) begin
        if (grst) begin
            value_q   <= '0;
            nospike_q <= 1'b1;
            spike     <= 1'b0;
        end else begin
            if (load) begin
                value_q   <= value;
                nospike_q <= nospike;
            end
            spike <= hit;
        end
    end

endmodule

// File: rtl/temporal_encoder.sv
// Race-logic temporal encoder: plays each accepted vector as one gamma cycle
// (a one-cycle set pulse, then G RUN cycles with per-channel spikes).
//
// state | meaning
// IDLE  | waiting for a vector, in_ready high
// SETUP | set pulse out, downstream latches arming
// RUN   | gcnt counts 0..G-1, spikes play out; ready again on the last cycle
module temporal_encoder
    import temporal_pkg::*;
#(
    parameter int GAMMA_CYCLE_WIDTH = 16,
    parameter int PULSE_WIDTH       = 8,
    parameter int NUM_CH            = 2,
    parameter int VAL_W             = $clog2(GAMMA_CYCLE_WIDTH)
) (
    input  logic                    aclk,
    input  logic                    grst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [NUM_CH*VAL_W-1:0] in_value,
    input  logic [NUM_CH-1:0]       in_nospike,
    output logic                    set,
    output logic [NUM_CH-1:0]       spike,
    output logic                    gamma_last
);

    localparam logic [VAL_W-1:0] G_LAST = VAL_W'(GAMMA_CYCLE_WIDTH - 1);

    enc_state_t       state;
    enc_state_t       state_nxt;
    logic [VAL_W-1:0] gcnt;
    logic [VAL_W-1:0] gcnt_nxt;
    logic             accept;
    logic             run_nxt;

    assign in_ready = !grst && ((state == IDLE) || ((state == RUN) && (gcnt == G_LAST)));
    assign accept   = in_valid && in_ready;
    assign run_nxt  = (state_nxt == RUN);

    // Next-state and gamma counter update.
    always_comb begin
        state_nxt = state;
        gcnt_nxt  = gcnt;
        unique case (state)
            IDLE: begin
                if (accept) state_nxt = SETUP;
            end
            SETUP: begin
                state_nxt = RUN;
                gcnt_nxt  = '0;
            end
            RUN: begin
                if (gcnt != G_LAST) begin
                    gcnt_nxt = gcnt + 1'b1;
                end else begin
                    gcnt_nxt  = '0;
                    state_nxt = accept ? SETUP : IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
                gcnt_nxt  = '0;
            end
        endcase
    end

    // State register plus registered set / gamma_last derived from next state.
    always_ff @(posedge aclk) begin
        if (grst) begin
            state      <= IDLE;
            gcnt       <= '0;
            set        <= 1'b0;
            gamma_last <= 1'b0;
        end else begin
            state      <= state_nxt;
            gcnt       <= gcnt_nxt;
            set        <= (state_nxt == SETUP);
            gamma_last <= run_nxt && (gcnt_nxt == G_LAST);
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        pulse_gen #(
            .GAMMA_CYCLE_WIDTH(GAMMA_CYCLE_WIDTH),
            .PULSE_WIDTH      (PULSE_WIDTH),
            .VAL_W            (VAL_W)
        ) u_pulse_gen (
            .aclk   (aclk),
            .grst   (grst),
            .load   (accept),
            .value  (in_value[i*VAL_W +: VAL_W]),
            .nospike(in_nospike[i]),
            .gcnt   (gcnt_nxt),
            .run    (run_nxt),
            .spike  (spike[i])
        );
    end

endmodule

// File: tb/tb_temporal_encoder.sv
// Bench for temporal_encoder: directed scenarios followed by random traffic,
// all checked cycle by cycle against a per-cycle timeline of expected outputs.
module tb_temporal_encoder;

    localparam int G    = 16;
    localparam int PW   = 8;
    localparam int NC   = 2;
    localparam int VW   = 4;
    localparam int MAXC = 2048;

    logic           aclk = 1'b0;
    logic           grst;
    logic           in_valid;
    logic           in_ready;
    logic [NC*VW-1:0] in_value;
    logic [NC-1:0]  in_nospike;
    logic           set;
    logic [NC-1:0]  spike;
    logic           gamma_last;

    temporal_encoder #(
        .GAMMA_CYCLE_WIDTH(G),
        .PULSE_WIDTH      (PW),
        .NUM_CH           (NC)
    ) dut (
        .aclk      (aclk),
        .grst      (grst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_value  (in_value),
        .in_nospike(in_nospike),
        .set       (set),
        .spike     (spike),
        .gamma_last(gamma_last)
    );

    always #5 aclk = ~aclk;

    // Expected-output timeline indexed by cycle number (cycle n ends at edge n).
    logic          exp_set [MAXC];
    logic          exp_gl  [MAXC];
    logic [NC-1:0] exp_sp  [MAXC];

    int checks = 0;
    int errors = 0;
    int n = 1;
    int next_ready = 0;
    int out_from = 2;
    int a_first = -1;
    int b_first = -1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%0h expected=%0h", tag, n, obs, exp);
        end
    endtask

    // Model of one gamma cycle accepted at edge k, from the timing rules.
    task automatic schedule(input int k, input int v0, input int v1, input logic n0, input logic n1);
        int vv [NC];
        logic nn [NC];
        vv[0] = v0; vv[1] = v1; nn[0] = n0; nn[1] = n1;
        exp_set[k+1] = 1'b1;
        for (int t = 0; t < G; t++) begin
            exp_gl[k+2+t] = (t == G-1);
            for (int c = 0; c < NC; c++)
                exp_sp[k+2+t][c] = !nn[c] && (t >= vv[c]) && (t < vv[c] + PW);
        end
        next_ready = k + G + 1;
        a_first = -1;
        b_first = -1;
    endtask

    // One clock cycle: drive inputs, check outputs of the current cycle, clock, update model.
    task automatic step(input logic r, input logic v, input int v0, input int v1,
                        input logic n0, input logic n1);
        logic rdy_m;
        grst       = r;
        in_valid   = v;
        in_value   = {VW'(v1), VW'(v0)};
        in_nospike = {n1, n0};
        #3;
        rdy_m = !r && (n >= next_ready);
        chk("in_ready", 32'(in_ready), 32'(rdy_m));
        if (n >= out_from) begin
            chk("set", 32'(set), 32'(exp_set[n]));
            chk("gamma_last", 32'(gamma_last), 32'(exp_gl[n]));
            chk("spike", 32'(spike), 32'(exp_sp[n]));
        end
        if (spike[0] === 1'b1 && a_first < 0) a_first = n;
        if (spike[1] === 1'b1 && b_first < 0) b_first = n;
        @(posedge aclk);
        if (r) begin
            for (int i = n + 1; i < n + G + 4; i++) begin
                exp_set[i] = 1'b0;
                exp_gl[i]  = 1'b0;
                exp_sp[i]  = '0;
            end
            next_ready = n + 1;
        end else if (v && rdy_m) begin
            schedule(n, v0, v1, n0, n1);
        end
        n++;
        #1;
    endtask

    task automatic idle(input int cnt);
        for (int i = 0; i < cnt; i++) step(1'b0, 1'b0, 0, 0, 1'b0, 1'b0);
    endtask

    // Feed a pair into a first-arrival comparison: a wins when it fires strictly first.
    task automatic pair(input int v0, input int v1, input logic n0, input logic n1);
        int k;
        logic a_wins_obs;
        logic a_wins_exp;
        k = n;
        step(1'b0, 1'b1, v0, v1, n0, n1);
        idle(G + 1);
        a_wins_obs = (a_first >= 0) && (b_first < 0 || a_first < b_first);
        a_wins_exp = !n0 && (n1 || v0 < v1);
        chk("pair_a_before_b", 32'(a_wins_obs), 32'(a_wins_exp));
        chk("pair_a_rise", 32'(a_first), n0 ? 32'hFFFF_FFFF : 32'(k + 2 + v0));
        chk("pair_b_rise", 32'(b_first), n1 ? 32'hFFFF_FFFF : 32'(k + 2 + v1));
    endtask

    initial begin
        for (int i = 0; i < MAXC; i++) begin
            exp_set[i] = 1'b0;
            exp_gl[i]  = 1'b0;
            exp_sp[i]  = '0;
        end

        // reset for 3 cycles, then idle with no valid
        repeat (3) step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(4);

        // basic encode {5,3}
        step(1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
        idle(20);

        // truncation on ch0 (v=12), ch1 nospike
        step(1'b0, 1'b1, 12, 0, 1'b0, 1'b1);
        idle(20);

        // back-to-back: {0,15} accepted, {1,1} held until the last RUN cycle
        step(1'b0, 1'b1, 0, 15, 1'b0, 1'b0);
        repeat (17) step(1'b0, 1'b1, 1, 1, 1'b0, 1'b0);
        idle(20);

        // reset mid-RUN at gcnt=6 with ch0 spiking, then a fresh encode
        step(1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
        idle(7);
        step(1'b1, 1'b0, 0, 0, 1'b0, 1'b0);
        idle(3);
        step(1'b0, 1'b1, 3, 5, 1'b0, 1'b0);
        idle(20);

        // downstream first-arrival pairing
        pair(3, 5, 1'b0, 1'b0);
        pair(5, 3, 1'b0, 1'b0);
        pair(4, 4, 1'b0, 1'b0);
        pair(4, 2, 1'b0, 1'b1);
        pair(4, 2, 1'b1, 1'b0);
        pair(7, 7, 1'b1, 1'b1);
        pair(15, 0, 1'b0, 1'b0);

        // random traffic with occasional resets
        for (int i = 0; i < 500; i++) begin
            logic r, v, n0, n1;
            int v0, v1;
            r  = ($urandom_range(59, 0) == 0);
            v  = ($urandom_range(3, 0) != 0);
            n0 = ($urandom_range(7, 0) == 0);
            n1 = ($urandom_range(7, 0) == 0);
            v0 = int'($urandom_range(G - 1, 0));
            v1 = int'($urandom_range(G - 1, 0));
            step(r, v, v0, v1, n0, n1);
        end
        idle(20);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/temporal_encoder.md
# temporal_encoder

Converts binary input values into race-logic spike pulses for the greater_than comparator array and other downstream temporal operators. Each accepted input vector is played out as one gamma cycle: a one-cycle `set` pulse arms downstream latches, then each channel's spike rises at the cycle offset given by its value. Each spike stays high for `PULSE_WIDTH` cycles. The block sits directly upstream of greater_than and drives its `set`, `a` and `b` inputs.

## Interface
- `GAMMA_CYCLE_WIDTH`, 16: RUN-phase cycles per gamma cycle (G); must be greater than `PULSE_WIDTH`.
- `PULSE_WIDTH`, 8: spike pulse length in cycles (PW).
- `NUM_CH`, 2: number of spike channels.
- `VAL_W`, `$clog2(GAMMA_CYCLE_WIDTH)`: value width (derived; do not override).

Ports:
- `aclk`  in  1  clock; the block has one clock.
- `grst`  in  1  reset; synchronous, active-high.
- `in_valid`  in  1  input vector valid.
- `in_ready`  out  1  block can accept a vector this cycle.
- `in_value`  in  NUM_CH×VAL_W  spike time per channel, 0..G-1.
- `in_nospike`  in  NUM_CH  per-channel "infinity": channel never fires this gamma cycle.
- `set`  out  1  one-cycle arm pulse preceding each gamma cycle.
- `spike`  out  NUM_CH  temporal-coded outputs.
- `gamma_last`  out  1  high in the final RUN cycle.

## Operation
- FSM states are IDLE, SETUP and RUN; there is a gamma counter `gcnt` (VAL_W bits).
- Accept rule: a vector is accepted when `in_valid && in_ready`. Values and nospike flags are latched into per-channel registers on acceptance.
- `in_ready` is high in IDLE.
- `in_ready` is also high in RUN when `gcnt == G-1`, which allows back-to-back gamma cycles.
- `in_ready` is low in SETUP and in all other RUN cycles.
- `in_ready` is low in any cycle where `grst` is high.
- Transitions:
  - IDLE→SETUP on accept.
  - SETUP→RUN unconditionally; `gcnt` is set to 0 on entry to RUN.
  - RUN with `gcnt < G-1`: `gcnt` increments.
  - RUN with `gcnt == G-1` and an accept: go to SETUP.
  - RUN with `gcnt == G-1` and no accept: go to IDLE.
- `set` is high exactly during SETUP. Spikes are never high during SETUP.
- `spike[i]` is high in RUN cycles where `!nospike[i]` and `v[i] <= gcnt <= v[i]+PW-1`.
- Truncation: if `v[i]+PW > G`, the pulse is cut at the end of RUN, giving G-v[i] cycles. No spike carries across a gamma boundary.
- Window arithmetic must be done VAL_W+1 bits wide so that `v+PW-1` does not wrap.
- `gamma_last` is high when in RUN and `gcnt == G-1`.
- Reset behaviour (`grst` high): state goes to IDLE and `gcnt` to 0. `set`, `spike` and `gamma_last` are 0; `in_ready` is 0 during reset and 1 from the first cycle after. Latched values clear to 0 and nospike flags clear to 1.
- Reset mid-operation: the gamma cycle in progress is abandoned with no resume. Outputs are 0 from the cycle after `grst` is sampled.

## Timing
- `set`, `spike` and `gamma_last` are registered outputs. `in_ready` is combinational from state, `gcnt` and `grst` only, never from `in_valid`.
- Let an accept occur at rising edge k:
  - `set` is high in cycle k+1.
  - `gcnt = 0` in cycle k+2.
  - `spike[i]` rises in cycle k+2+v[i].
  - `gamma_last` is high in cycle k+2+G-1.
- Gamma period is G+1 cycles when back-to-back (G RUN cycles plus 1 SETUP). With a next accept at edge k+G+1, `set` follows in cycle k+G+2.
- An accept in the last RUN cycle does not alter that cycle's spike outputs; the new values take effect from SETUP onward.

## Structure
- Shared package `temporal_pkg` holds the state enum typedef `enc_state_t` (IDLE, SETUP, RUN). The same package is shared with the downstream temporal decoder.
- Sub-module `pulse_gen`, one instance per channel:
  - inputs: `aclk`, `grst`, `load`, value, nospike, `gcnt`, `run`;
  - output: registered `spike`;
  - contains the window compare and truncation logic.
- The top level contains the FSM, `gcnt` and the handshake.

## Test plan
- Reset and idle: hold `grst` for 3 cycles. Expect all outputs 0 and `in_ready` 0 during reset, then `in_ready` 1 from the next cycle. No `set` while `in_valid` is 0.
- Basic encode (G=16, PW=8): accept `in_value = {5,3}` at edge k.
  - `set` is high in cycle k+1 only.
  - `spike[0]` (v=3) is high in cycles k+5..k+12.
  - `spike[1]` (v=5) is high in cycles k+7..k+14.
  - `gamma_last` is high in cycle k+17.
- Truncation and no-spike: accept `{nospike, v=12}`.
  - `spike[0]` is high in cycles k+14..k+17 only (4 cycles).
  - `spike[1]` stays 0 for the whole gamma cycle.
- Back-to-back: hold `in_valid` with `{0,15}` then `{1,1}`.
  - The second accept lands at k+17.
  - `set` is high in cycle k+18.
  - `spike[0]` v=0 high k+2..k+9 then v=1 high k+20..k+27.
  - `spike[1]` v=15 high k+17 only then v=1 high k+20..k+27.
  - `in_ready` is low in cycles k+1..k+16.
- Reset mid-RUN: assert `grst` at `gcnt = 6` with a spike active.
  - All outputs are 0 in the following cycle; the state is IDLE.
  - A fresh accept afterwards follows the basic-encode timing.
- Downstream pairing: drive greater_than with `a = spike[0]`, `b = spike[1]` and `set` from this block. Check its output against a reference min/greater-than model for values {3,5}, {5,3}, {4,4} and nospike cases.
